// File: rtl/fv_mem_split_tracker.sv
// -----------------------------------------------------------------------------
// fv_mem_split_tracker
//
// Purpose:
//   Load/store constraint tracker for SQED-style formal runs. Each cycle it
//   samples NUM_CH load/store channels and does the following:
//     - checks every effective address against the data memory range;
//     - checks that the address lies in the half that matches the
//       original/duplicate split bit;
//     - counts original and duplicate operations (saturating counters);
//     - queues original stores in an address FIFO and retires them against
//       later duplicate stores, in order.
//   Errors are sticky until rst. qed_ready reports when the tracker is idle
//   and the original and duplicate op counts agree.
//
// Configuration macro:
//   FV_STORE_DATA_CHECK_EN - when defined, FIFO entries also hold store data,
//                            and a duplicate store must match the head data.
//                            When undefined, ld_st_data is ignored and
//                            matching uses the address only.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous, active-high reset
//   ld_st_valid    [NUM_CH]        per-channel valid
//   ld_st_is_store [NUM_CH]        1 = store, 0 = load
//   ld_st_dup      [NUM_CH]        0 = original, 1 = duplicate
//   ld_st_effaddr  [NUM_CH*ADDR_W] packed effective addresses
//   ld_st_data     [NUM_CH*DATA_W] packed store data
//   addr_ok        [NUM_CH]        registered range and split pass (1 when idle)
//   orig_cnt       [CNT_W]         accepted original ops, saturating
//   dup_cnt        [CNT_W]         accepted duplicate ops, saturating
//   pend_cnt       [log2(DEPTH)+1] FIFO occupancy
//   range_err                      sticky: address out of DMEM
//   split_err                      sticky: address in the wrong half
//   order_err                      sticky: dup mismatch, underflow or overflow
//   qed_ready                      registered: IDLE and orig_cnt == dup_cnt
// -----------------------------------------------------------------------------
module fv_mem_split_tracker #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DMEM_SIZE = 1024,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ld_st_valid,
  input  logic [NUM_CH-1:0]          ld_st_is_store,
  input  logic [NUM_CH-1:0]          ld_st_dup,
  input  logic [NUM_CH*ADDR_W-1:0]   ld_st_effaddr,
  input  logic [NUM_CH*DATA_W-1:0]   ld_st_data,
  output logic [NUM_CH-1:0]          addr_ok,
  output logic [CNT_W-1:0]           orig_cnt,
  output logic [CNT_W-1:0]           dup_cnt,
  output logic [$clog2(DEPTH):0]     pend_cnt,
  output logic                       range_err,
  output logic                       split_err,
  output logic                       order_err,
  output logic                       qed_ready
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;

  // Address compares use one extra bit so that head + DMEM_SIZE/2 never wraps.
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(DMEM_SIZE);
  localparam logic [ADDR_W:0]   HALF     = (ADDR_W+1)'(DMEM_SIZE / 2);
  localparam logic [PEND_W:0]   DEPTH_X  = (PEND_W+1)'(DEPTH);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [CNT_W:0]    CNT_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]    CNT_MAX  = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
`ifdef FV_STORE_DATA_CHECK_EN
  logic [DATA_W-1:0] data_mem [DEPTH];
`else
  logic unused_data;
  assign unused_data = ^ld_st_data;
`endif

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] pop_n, push_n;
  logic [NUM_CH-1:0] addr_ok_q, addr_ok_d;
  logic [NUM_CH-1:0] push_en;
  logic [PTR_W-1:0]  push_idx [NUM_CH];
  logic [ADDR_W:0]   ch_addr [NUM_CH];
  logic [ADDR_W:0]   expect_addr;
  logic [PTR_W-1:0]  head_idx;
  logic              in_range, upper;
  logic [CNT_W-1:0]  orig_cnt_q, orig_cnt_d;
  logic [CNT_W-1:0]  dup_cnt_q, dup_cnt_d;
  logic [CNT_W:0]    orig_sum, dup_sum;
  logic              new_range, new_split, new_order;
  logic              range_err_q, range_err_d;
  logic              split_err_q, split_err_d;
  logic              order_err_q, order_err_d;
  logic              qed_ready_q, qed_ready_d;

  // Per-cycle next-state: address checks, FIFO pops then pushes, counters, FSM.
  always_comb begin
    addr_ok_d   = '1;
    new_range   = 1'b0;
    new_split   = 1'b0;
    new_order   = 1'b0;
    pop_n       = '0;
    push_n      = '0;
    push_en     = '0;
    head_idx    = '0;
    expect_addr = '0;
    in_range    = 1'b0;
    upper       = 1'b0;
    orig_sum    = {1'b0, orig_cnt_q};
    dup_sum     = {1'b0, dup_cnt_q};

    // Range / split checks and op counting.
    for (int i = 0; i < NUM_CH; i++) begin
      push_idx[i] = '0;
      ch_addr[i]  = {1'b0, ld_st_effaddr[i*ADDR_W +: ADDR_W]};
      in_range    = ch_addr[i] < LIMIT;
      upper       = ch_addr[i] >= HALF;
      if (ld_st_valid[i]) begin
        addr_ok_d[i] = in_range & (ld_st_dup[i] ? upper : ~upper);
        // An out-of-range address is reported as a range error only; it does
        // not belong to either half.
        if (!in_range) begin
          new_range = 1'b1;
        end else if (ld_st_dup[i] != upper) begin
          new_split = 1'b1;
        end else begin
          new_split = new_split;
        end
        if (ld_st_dup[i]) begin
          dup_sum = dup_sum + CNT_ONE;
        end else begin
          orig_sum = orig_sum + CNT_ONE;
        end
      end else begin
        addr_ok_d[i] = 1'b1;
      end
    end

    // Duplicate stores retire FIFO entries present at the start of the cycle.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ld_st_valid[i] && ld_st_is_store[i] && ld_st_dup[i]) begin
        if (pop_n == pend_q) begin
          new_order = 1'b1;
        end else begin
          head_idx    = rd_ptr_q + pop_n[PTR_W-1:0];
          expect_addr = {1'b0, addr_mem[head_idx]} + HALF;
          if (ch_addr[i] != expect_addr) begin
            new_order = 1'b1;
          end else begin
            new_order = new_order;
          end
`ifdef FV_STORE_DATA_CHECK_EN
          if (ld_st_data[i*DATA_W +: DATA_W] != data_mem[head_idx]) begin
            new_order = 1'b1;
          end else begin
            new_order = new_order;
          end
`endif
          pop_n = pop_n + PEND_ONE;
        end
      end else begin
        pop_n = pop_n;
      end
    end

    // Original stores append; slots freed by this cycle's pops are reusable
    // because the popped entries were already read above.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ld_st_valid[i] && ld_st_is_store[i] && !ld_st_dup[i]) begin
        if (({1'b0, pend_q} + {1'b0, push_n}) < (DEPTH_X + {1'b0, pop_n})) begin
          push_en[i]  = 1'b1;
          push_idx[i] = wr_ptr_q + push_n[PTR_W-1:0];
          push_n      = push_n + PEND_ONE;
        end else begin
          new_order = 1'b1;
        end
      end else begin
        push_n = push_n;
      end
    end

    rd_ptr_d    = rd_ptr_q + pop_n[PTR_W-1:0];
    wr_ptr_d    = wr_ptr_q + push_n[PTR_W-1:0];
    pend_d      = pend_q + push_n - pop_n;
    orig_cnt_d  = (orig_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : orig_sum[CNT_W-1:0];
    dup_cnt_d   = (dup_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : dup_sum[CNT_W-1:0];
    range_err_d = range_err_q | new_range;
    split_err_d = split_err_q | new_split;
    order_err_d = order_err_q | new_order;

    if (range_err_d || split_err_d || order_err_d) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE, ST_PEND: state_d = (pend_d == '0) ? ST_IDLE : ST_PEND;
        ST_ERR:           state_d = ST_ERR;
        default:          state_d = ST_ERR;
      endcase
    end

    qed_ready_d = (state_d == ST_IDLE) && (orig_cnt_d == dup_cnt_d);
  end

  // Control state, counters, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      pend_q      <= '0;
      addr_ok_q   <= '0;
      orig_cnt_q  <= '0;
      dup_cnt_q   <= '0;
      range_err_q <= 1'b0;
      split_err_q <= 1'b0;
      order_err_q <= 1'b0;
      qed_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pend_q      <= pend_d;
      addr_ok_q   <= addr_ok_d;
      orig_cnt_q  <= orig_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
      range_err_q <= range_err_d;
      split_err_q <= split_err_d;
      order_err_q <= order_err_d;
      qed_ready_q <= qed_ready_d;
    end
  end

  // FIFO storage; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst && push_en[i]) begin
        addr_mem[push_idx[i]] <= ld_st_effaddr[i*ADDR_W +: ADDR_W];
`ifdef FV_STORE_DATA_CHECK_EN
        data_mem[push_idx[i]] <= ld_st_data[i*DATA_W +: DATA_W];
`endif
      end
    end
  end

  assign addr_ok   = addr_ok_q;
  assign orig_cnt  = orig_cnt_q;
  assign dup_cnt   = dup_cnt_q;
  assign pend_cnt  = pend_q;
  assign range_err = range_err_q;
  assign split_err = split_err_q;
  assign order_err = order_err_q;
  assign qed_ready = qed_ready_q;

endmodule

// File: tb/tb_fv_mem_split_tracker.sv
// -----------------------------------------------------------------------------
// tb_fv_mem_split_tracker
//
// Directed, table-driven bench for fv_mem_split_tracker with default
// parameters (2 channels, DMEM_SIZE 1024, DEPTH 8, 8-bit counters). Each table
// row is one clock cycle: inputs are applied, and all outputs are compared
// just after the following rising edge. A hand-written loop covers counter
// saturation.
// -----------------------------------------------------------------------------
module tb_fv_mem_split_tracker;

`ifdef FV_STORE_DATA_CHECK_EN
  localparam logic DCHK = 1'b1;
`else
  localparam logic DCHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  ld_st_valid;
  logic [1:0]  ld_st_is_store;
  logic [1:0]  ld_st_dup;
  logic [63:0] ld_st_effaddr;
  logic [63:0] ld_st_data;
  logic [1:0]  addr_ok;
  logic [7:0]  orig_cnt;
  logic [7:0]  dup_cnt;
  logic [3:0]  pend_cnt;
  logic        range_err;
  logic        split_err;
  logic        order_err;
  logic        qed_ready;

  int nvec;
  int nerr;

  typedef struct {
    logic        r;
    logic [1:0]  vl;
    logic [1:0]  st;
    logic [1:0]  dp;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ok;
    logic [7:0]  oc;
    logic [7:0]  dc;
    logic [3:0]  pc;
    logic        re;
    logic        se;
    logic        oe;
    logic        qr;
  } vec_t;

  vec_t tbl[$];

  fv_mem_split_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .ld_st_valid    (ld_st_valid),
    .ld_st_is_store (ld_st_is_store),
    .ld_st_dup      (ld_st_dup),
    .ld_st_effaddr  (ld_st_effaddr),
    .ld_st_data     (ld_st_data),
    .addr_ok        (addr_ok),
    .orig_cnt       (orig_cnt),
    .dup_cnt        (dup_cnt),
    .pend_cnt       (pend_cnt),
    .range_err      (range_err),
    .split_err      (split_err),
    .order_err      (order_err),
    .qed_ready      (qed_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [1:0] vl, input logic [1:0] st,
                             input logic [1:0] dp, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] ok,
                             input logic [7:0] oc, input logic [7:0] dc, input logic [3:0] pc,
                             input logic re, input logic se, input logic oe, input logic qr);
    vec_t t;
    t.r = r;   t.vl = vl; t.st = st; t.dp = dp;
    t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.ok = ok; t.oc = oc; t.dc = dc; t.pc = pc;
    t.re = re; t.se = se; t.oe = oe; t.qr = qr;
    return t;
  endfunction

  // Idle cycle (no channel valid) with the given expected outputs.
  function automatic vec_t idle(input logic r, input logic [1:0] ok, input logic [7:0] oc,
                                input logic [7:0] dc, input logic [3:0] pc, input logic re,
                                input logic se, input logic oe, input logic qr);
    return v(r, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, ok, oc, dc, pc, re, se, oe, qr);
  endfunction

  function automatic vec_t rst_row();
    return idle(1'b1, 2'b00, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic drive(input vec_t t);
    rst            = t.r;
    ld_st_valid    = t.vl;
    ld_st_is_store = t.st;
    ld_st_dup      = t.dp;
    ld_st_effaddr  = {t.a1, t.a0};
    ld_st_data     = {t.d1, t.d0};
  endtask

  task automatic check(input string name, input vec_t t);
    nvec++;
    if (addr_ok !== t.ok || orig_cnt !== t.oc || dup_cnt !== t.dc || pend_cnt !== t.pc ||
        range_err !== t.re || split_err !== t.se || order_err !== t.oe || qed_ready !== t.qr) begin
      nerr++;
      $display("FAIL %s: got ok=%b oc=%0d dc=%0d pc=%0d re=%b se=%b oe=%b qr=%b, want ok=%b oc=%0d dc=%0d pc=%0d re=%b se=%b oe=%b qr=%b",
               name, addr_ok, orig_cnt, dup_cnt, pend_cnt, range_err, split_err, order_err, qed_ready,
               t.ok, t.oc, t.dc, t.pc, t.re, t.se, t.oe, t.qr);
    end
  endtask

  initial begin
    vec_t t;
    nvec = 0;
    nerr = 0;
    drive(rst_row());

    // Reset, then idle.
    tbl.push_back(rst_row());
    for (int k = 0; k < 5; k++) tbl.push_back(idle(1'b0, 2'b11, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Original store on ch0, its duplicate on ch1 one cycle later.
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b00, 32'h010, 32'h0, 32'hAB, 32'h0, 2'b11, 8'd1, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b10, 2'b10, 2'b10, 32'h0, 32'h210, 32'h0, 32'hAB, 2'b11, 8'd1, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Loads count but do not touch the FIFO.
    tbl.push_back(v(1'b0, 2'b11, 2'b00, 2'b10, 32'h100, 32'h300, 32'h0, 32'h0, 2'b11, 8'd2, 8'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Two pushes, then pop+push in one cycle, then two in-order pops.
    tbl.push_back(v(1'b0, 2'b11, 2'b11, 2'b00, 32'h040, 32'h050, 32'h0, 32'h0, 2'b11, 8'd4, 8'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b11, 2'b11, 2'b01, 32'h240, 32'h060, 32'h0, 32'h0, 2'b11, 8'd5, 8'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b11, 2'b11, 2'b11, 32'h250, 32'h260, 32'h0, 32'h0, 2'b11, 8'd5, 8'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(idle(1'b0, 2'b11, 8'd5, 8'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Original load in the upper half: split error, addr_ok[0] low.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b01, 2'b00, 2'b00, 32'h300, 32'h0, 32'h0, 32'h0, 2'b10, 8'd1, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(idle(1'b0, 2'b11, 8'd1, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    // Out-of-range load on ch1.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h400, 32'h0, 32'h0, 2'b01, 8'd1, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Duplicate store with FIFO empty: order error held for 10 cycles.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b01, 32'h210, 32'h0, 32'h0, 32'h0, 2'b11, 8'd0, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 10; k++) tbl.push_back(idle(1'b0, 2'b11, 8'd0, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // Same-cycle push and pop: no bypass, so the pop underflows.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b11, 2'b11, 2'b10, 32'h030, 32'h230, 32'h0, 32'h0, 2'b11, 8'd1, 8'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    // Fill to DEPTH, overflow by one, then retire the oldest entry.
    tbl.push_back(rst_row());
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(1'b0, 2'b11, 2'b11, 2'b00, 32'(32 * k), 32'(32 * k + 16), 32'h0, 32'h0, 2'b11,
                      8'(2 * (k + 1)), 8'd0, 4'(2 * (k + 1)), 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2'b11, 8'd9, 8'd0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b01, 32'h200, 32'h0, 32'h0, 32'h0, 2'b11, 8'd9, 8'd1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0));
    // Duplicate address mismatch.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b00, 32'h020, 32'h0, 32'h11, 32'h0, 2'b11, 8'd1, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b10, 2'b10, 2'b10, 32'h0, 32'h221, 32'h0, 32'h0, 2'b11, 8'd1, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // Matching address, differing data: error only with the data check built in.
    tbl.push_back(rst_row());
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b00, 32'h020, 32'h0, 32'h11, 32'h0, 2'b11, 8'd1, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 2'b01, 2'b01, 2'b01, 32'h220, 32'h0, 32'h12, 32'h0, 2'b11, 8'd1, 8'd1, 4'd0, 1'b0, 1'b0, DCHK, ~DCHK));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), tbl[k]);
    end

    // Counter saturation: 127 cycles of two original loads reach 254,
    // the next cycle would reach 256 and clamps at 255.
    drive(rst_row());
    @(posedge clk);
    #1;
    check("sat_reset", rst_row());
    t = v(1'b0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, 2'b11, 8'd254, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(t);
    for (int k = 0; k < 127; k++) @(posedge clk);
    #1;
    check("sat_254", t);
    t.oc = 8'd255;
    @(posedge clk);
    #1;
    check("sat_255", t);
    @(posedge clk);
    #1;
    check("sat_hold", t);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
